// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF/MEM requester ports and the memory macro port for mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline + memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// data first, and stalls the pipeline until every pending request is served.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_dm_q, own_dm_d;
  logic              own_we_q, own_we_d;
  logic              done_i_q, done_i_d;
  logic              done_d_q, done_d_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic issue, mem_we_c, if_ready_c, dm_ready_c, stall_c;
  logic dm_elig, if_elig;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_dm_d    = own_dm_q;
    own_we_d    = own_we_q;
    done_i_d    = done_i_q;
    done_d_d    = done_d_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    issue       = 1'b0;
    mem_we_c    = 1'b0;
    if_ready_c  = 1'b0;
    dm_ready_c  = 1'b0;
    dm_elig     = bus.dm_req & ~done_d_q;
    if_elig     = bus.if_req & ~done_i_q;

    case (state_q)
      IDLE: begin
        if (dm_elig || if_elig) begin
          issue    = 1'b1;
          own_dm_d = dm_elig;
          own_we_d = dm_elig & bus.dm_we;
          mem_we_c = dm_elig & bus.dm_we;
          cnt_d    = CNT_W'(MEM_LAT);
          state_d  = WAIT;
          if (dm_elig) begin
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
          end else begin
            mem_addr_d  = bus.if_addr;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (!own_dm_q)      if_rdata_d = bus.mem_rdata;
          else if (!own_we_q) dm_rdata_d = bus.mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (own_dm_q) begin
          dm_ready_c = 1'b1;
          done_d_d   = 1'b1;
        end else begin
          if_ready_c = 1'b1;
          done_i_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_c = (bus.if_req & ~done_i_q & ~if_ready_c) |
              (bus.dm_req & ~done_d_q & ~dm_ready_c);
    // Pipeline advance wins over the RESP-edge done set: a held request is a new one.
    if (!stall_c) begin
      done_i_d = 1'b0;
      done_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_dm_q    <= 1'b0;
      own_we_q    <= 1'b0;
      done_i_q    <= 1'b0;
      done_d_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_dm_q    <= own_dm_d;
      own_we_q    <= own_we_d;
      done_i_q    <= done_i_d;
      done_d_q    <= done_d_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Issue is combinational from IDLE, so gate it with reset to keep the strobe low in reset.
  assign bus.mem_en    = issue & rst_n;
  assign bus.mem_we    = mem_we_c & rst_n;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = if_ready_c;
  assign bus.dm_ready  = dm_ready_c;
  assign bus.stall     = stall_c;
endmodule
